// File: rtl/ast_arb_mux_pkg.sv
`default_nettype none
// ============================================================================
// Package : usr_types_and_params
// Shared widths and arbitration state type for the Avalon-ST N:1 multiplexer.
// Rev     : 1.0
// ============================================================================
package usr_types_and_params;

    localparam int DATA_WIDTH    = 64;
    localparam int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8);
    localparam int CHANNEL_WIDTH = 8;
    localparam int RX_DIR        = 4;
    localparam int DIR_SEL_WIDTH = $clog2(RX_DIR);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/ast_arb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Stateless rotating-priority arbiter: the first requester after the previous
// winner (modulo RX_DIR) is granted.
// Rev    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int RX_DIR    = 4,
    parameter int SEL_WIDTH = $clog2(RX_DIR)
) (
    input  logic [RX_DIR-1:0]    i_req,
    input  logic [SEL_WIDTH-1:0] i_last_grant,
    output logic [RX_DIR-1:0]    o_grant_oh,
    output logic [SEL_WIDTH-1:0] o_grant_idx,
    output logic                 o_grant_vld
);

    int w_dist;
    int w_best;

    // Distance 0 is the slot right after the previous winner; smallest distance wins.
    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        w_best      = RX_DIR;
        w_dist      = 0;
        for (int j = 0; j < RX_DIR; j++) begin
            w_dist = (j + RX_DIR - 1 - int'(i_last_grant)) % RX_DIR;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best      = w_dist;
                o_grant_idx = SEL_WIDTH'(j);
                o_grant_vld = 1'b1;
            end
        end
        o_grant_oh[o_grant_idx] = o_grant_vld;
    end

endmodule
`default_nettype wire

// File: rtl/ast_arb_mux.sv
`default_nettype none
// ============================================================================
// Module : ast_arb_mux
// Avalon-ST N:1 packet multiplexer, round-robin and packet-atomic, with the
// source index of every beat carried on dir_o.
// Rev    : 1.0
// ============================================================================
module ast_arb_mux
    import usr_types_and_params::*;
(
    input  logic                     clk_i,
    input  logic                     srst_n_i,
    input  logic [DATA_WIDTH-1:0]    ast_data_i          [RX_DIR-1:0],
    input  logic [RX_DIR-1:0]        ast_startofpacket_i,
    input  logic [RX_DIR-1:0]        ast_endofpacket_i,
    input  logic [RX_DIR-1:0]        ast_valid_i,
    input  logic [EMPTY_WIDTH-1:0]   ast_empty_i         [RX_DIR-1:0],
    input  logic [CHANNEL_WIDTH-1:0] ast_channel_i       [RX_DIR-1:0],
    output logic [RX_DIR-1:0]        ast_ready_o,
    output logic [DATA_WIDTH-1:0]    ast_data_o,
    output logic                     ast_startofpacket_o,
    output logic                     ast_endofpacket_o,
    output logic                     ast_valid_o,
    output logic [EMPTY_WIDTH-1:0]   ast_empty_o,
    output logic [CHANNEL_WIDTH-1:0] ast_channel_o,
    output logic [DIR_SEL_WIDTH-1:0] dir_o,
    input  logic                     ast_ready_i
);

    localparam logic [DIR_SEL_WIDTH-1:0] c_LAST_INIT = DIR_SEL_WIDTH'(RX_DIR - 1);

    arb_state_t                 r_state;
    logic [DIR_SEL_WIDTH-1:0]   r_grant;
    logic [DIR_SEL_WIDTH-1:0]   r_last_grant;
    logic [DATA_WIDTH-1:0]      r_data;
    logic                       r_sop;
    logic                       r_eop;
    logic                       r_valid;
    logic [EMPTY_WIDTH-1:0]     r_empty;
    logic [CHANNEL_WIDTH-1:0]   r_channel;
    logic [DIR_SEL_WIDTH-1:0]   r_dir;

    logic [RX_DIR-1:0]          w_arb_oh;
    logic [DIR_SEL_WIDTH-1:0]   w_arb_idx;
    logic                       w_arb_vld;
    logic [DIR_SEL_WIDTH-1:0]   w_sel;
    logic                       w_out_free;
    logic                       w_in_acc;
    logic                       w_in_eop;

    rr_arbiter #(
        .RX_DIR    (RX_DIR),
        .SEL_WIDTH (DIR_SEL_WIDTH)
    ) u_rr_arbiter (
        .i_req        (ast_valid_i),
        .i_last_grant (r_last_grant),
        .o_grant_oh   (w_arb_oh),
        .o_grant_idx  (w_arb_idx),
        .o_grant_vld  (w_arb_vld)
    );

    // Single-entry output stage: it can take a beat when empty or being drained.
    assign w_out_free = !r_valid || ast_ready_i;
    assign w_sel      = (r_state == IDLE) ? w_arb_idx : r_grant;
    assign w_in_acc   = |(ast_ready_o & ast_valid_i);
    assign w_in_eop   = ast_endofpacket_i[w_sel];

    always_comb begin
        ast_ready_o = '0;
        if (srst_n_i) begin
            if (r_state == IDLE) begin
                ast_ready_o = w_arb_oh & {RX_DIR{w_out_free}};
            end else begin
                ast_ready_o[r_grant] = w_out_free;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= c_LAST_INIT;
            r_data       <= '0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_valid      <= 1'b0;
            r_empty      <= '0;
            r_channel    <= '0;
            r_dir        <= '0;
        end else begin
            if (w_in_acc) begin
                r_valid   <= 1'b1;
                r_data    <= ast_data_i[w_sel];
                r_sop     <= ast_startofpacket_i[w_sel];
                r_eop     <= w_in_eop;
                r_empty   <= ast_empty_i[w_sel];
                r_channel <= ast_channel_i[w_sel];
                r_dir     <= w_sel;
            end else if (ast_ready_i) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_arb_vld) begin
                        r_grant <= w_arb_idx;
                        // A single-beat packet is granted and released in one cycle.
                        if (w_in_acc && w_in_eop) begin
                            r_last_grant <= w_arb_idx;
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (w_in_acc && w_in_eop) begin
                        r_last_grant <= r_grant;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ast_data_o          = r_data;
    assign ast_startofpacket_o = r_sop;
    assign ast_endofpacket_o   = r_eop;
    assign ast_valid_o         = r_valid;
    assign ast_empty_o         = r_empty;
    assign ast_channel_o       = r_channel;
    assign dir_o               = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_ast_arb_mux.sv
`default_nettype none
// ============================================================================
// Module : tb_ast_arb_mux
// Scoreboard bench for ast_arb_mux with a packet-level round-robin model.
// Rev    : 1.0
// ============================================================================
module tb_ast_arb_mux;
    import usr_types_and_params::*;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    data;
        logic                     sop;
        logic                     eop;
        logic [EMPTY_WIDTH-1:0]   empty;
        logic [CHANNEL_WIDTH-1:0] chan;
        logic [DIR_SEL_WIDTH-1:0] dir;
    } beat_t;

    logic                     clk = 1'b0;
    logic                     srst_n;
    logic [DATA_WIDTH-1:0]    d_i    [RX_DIR-1:0];
    logic [RX_DIR-1:0]        sop_i;
    logic [RX_DIR-1:0]        eop_i;
    logic [RX_DIR-1:0]        vld_i;
    logic [EMPTY_WIDTH-1:0]   emp_i  [RX_DIR-1:0];
    logic [CHANNEL_WIDTH-1:0] chan_i [RX_DIR-1:0];
    logic [RX_DIR-1:0]        rdy_o;
    logic [DATA_WIDTH-1:0]    data_o;
    logic                     sop_o;
    logic                     eop_o;
    logic                     valid_o;
    logic [EMPTY_WIDTH-1:0]   emp_o;
    logic [CHANNEL_WIDTH-1:0] chan_o;
    logic [DIR_SEL_WIDTH-1:0] dir_o;
    logic                     ready_i;

    always #5 clk = ~clk;

    ast_arb_mux dut (
        .clk_i               (clk),
        .srst_n_i            (srst_n),
        .ast_data_i          (d_i),
        .ast_startofpacket_i (sop_i),
        .ast_endofpacket_i   (eop_i),
        .ast_valid_i         (vld_i),
        .ast_empty_i         (emp_i),
        .ast_channel_i       (chan_i),
        .ast_ready_o         (rdy_o),
        .ast_data_o          (data_o),
        .ast_startofpacket_o (sop_o),
        .ast_endofpacket_o   (eop_o),
        .ast_valid_o         (valid_o),
        .ast_empty_o         (emp_o),
        .ast_channel_o       (chan_o),
        .dir_o               (dir_o),
        .ast_ready_i         (ready_i)
    );

    beat_t out_b;
    assign out_b = {data_o, sop_o, eop_o, emp_o, chan_o, dir_o};

    int vectors     = 0;
    int miscompares = 0;

    beat_t             txq [RX_DIR][$];
    beat_t             exp_q[$];
    logic [RX_DIR-1:0] acc;
    int                owner    = -1;
    int                last_win = RX_DIR - 1;
    bit                strict;
    bit                gaps;
    bit                rnd_ready;
    bit                have_last;
    beat_t             last_beat;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endfunction

    function automatic void fail_now(string name, string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, what);
    endfunction

    // Reference arbitration: first valid input after the previous winner, modulo RX_DIR.
    function automatic int predict(logic [RX_DIR-1:0] req);
        for (int k = 1; k <= RX_DIR; k++) begin
            int j;
            j = (last_win + k) % RX_DIR;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    function automatic void load_pkt(int i, int len, logic [DATA_WIDTH-1:0] base,
                                     logic [EMPTY_WIDTH-1:0] emp, logic [CHANNEL_WIDTH-1:0] ch);
        for (int k = 0; k < len; k++) begin
            beat_t b;
            b.data  = (base == 0) ? {$urandom, $urandom} : base + DATA_WIDTH'(k);
            b.sop   = (k == 0);
            b.eop   = (k == len - 1);
            b.empty = b.eop ? emp : '0;
            b.chan  = ch;
            b.dir   = '0;
            txq[i].push_back(b);
        end
    endfunction

    function automatic bit busy();
        for (int i = 0; i < RX_DIR; i++) if (txq[i].size() > 0) return 1'b1;
        return (vld_i != '0) || (exp_q.size() > 0);
    endfunction

    function automatic void check_cycle();
        int n;
        int src;
        n   = $countones(acc);
        src = -1;
        chk("ready_onehot", ($countones(rdy_o) > 1), 0);
        if (rdy_o != '0) chk("ready_needs_free", (!valid_o || ready_i), 1);
        if (have_last) chk("latency", {valid_o, out_b}, {1'b1, last_beat});
        have_last = 1'b0;
        if (n > 1) begin
            chk("multi_accept", n, 1);
        end else if (n == 1) begin
            for (int i = 0; i < RX_DIR; i++) if (acc[i]) src = i;
            if (owner >= 0) begin
                chk("no_interleave", src, owner);
            end else begin
                if (strict) chk("rr_winner", src, predict(vld_i));
                last_win = src;
            end
            owner          = txq[src][0].eop ? -1 : src;
            last_beat      = txq[src][0];
            last_beat.dir  = DIR_SEL_WIDTH'(src);
            have_last      = 1'b1;
        end
    endfunction

    function automatic void update();
        for (int i = 0; i < RX_DIR; i++) begin
            if (acc[i]) begin
                beat_t b;
                b     = txq[i].pop_front();
                b.dir = DIR_SEL_WIDTH'(i);
                exp_q.push_back(b);
            end
        end
        for (int i = 0; i < RX_DIR; i++) begin
            if (!(vld_i[i] && !acc[i])) begin
                if (txq[i].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                    d_i[i]    = txq[i][0].data;
                    sop_i[i]  = txq[i][0].sop;
                    eop_i[i]  = txq[i][0].eop;
                    emp_i[i]  = txq[i][0].empty;
                    chan_i[i] = txq[i][0].chan;
                    vld_i[i]  = 1'b1;
                end else begin
                    vld_i[i] = 1'b0;
                end
            end
        end
        ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    task automatic step();
        @(negedge clk);
        acc = srst_n ? (vld_i & rdy_o) : '0;
        if (srst_n) check_cycle();
        @(posedge clk);
        #1;
        update();
    endtask

    task automatic drain(int budget);
        int c;
        c = 0;
        while (busy() && c < budget) begin
            step();
            c++;
        end
        if (c >= budget) fail_now("drain_timeout", "traffic did not complete within the cycle budget");
    endtask

    task automatic do_reset(int cycles, bit keep_valid);
        srst_n = 1'b0;
        for (int i = 0; i < RX_DIR; i++) txq[i].delete();
        exp_q.delete();
        owner     = -1;
        last_win  = RX_DIR - 1;
        have_last = 1'b0;
        if (!keep_valid) vld_i = '0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            chk("rst_ready", rdy_o, 0);
            if (k > 0) chk("rst_outputs", {valid_o, out_b}, 0);
            @(posedge clk);
            #1;
        end
        srst_n  = 1'b1;
        ready_i = 1'b1;
    endtask

    // Output-side monitor: pops the scoreboard on every accepted output beat.
    initial begin
        beat_t b;
        beat_t prev_b;
        bit    prev_stall;
        prev_stall = 1'b0;
        prev_b     = '0;
        forever begin
            @(negedge clk);
            if (srst_n === 1'b1) begin
                if (prev_stall) chk("stall_hold", {valid_o, out_b}, {1'b1, prev_b});
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        fail_now("out_extra", $sformatf("beat %0h with empty scoreboard", out_b));
                    end else begin
                        b = exp_q.pop_front();
                        chk("out_beat", out_b, b);
                    end
                end
                prev_stall = valid_o && !ready_i;
                prev_b     = out_b;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        int got;
        int c;
        strict    = 1'b1;
        gaps      = 1'b0;
        rnd_ready = 1'b0;
        ready_i   = 1'b1;
        for (int i = 0; i < RX_DIR; i++) begin
            d_i[i]    = {$urandom, $urandom};
            emp_i[i]  = EMPTY_WIDTH'(i);
            chan_i[i] = CHANNEL_WIDTH'(i + 1);
        end
        sop_i = '1;
        eop_i = '0;
        vld_i = '1;

        // Reset held with every input requesting.
        do_reset(3, 1'b1);
        vld_i = '0;

        // Single 4-beat packet from input 2, data 1..4.
        load_pkt(2, 4, 64'd1, '0, 8'h00);
        drain(100);

        // Fairness: all inputs hold 2-beat packets.
        do_reset(2, 1'b0);
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < RX_DIR; i++) load_pkt(i, 2, '0, EMPTY_WIDTH'(i), CHANNEL_WIDTH'(16 * i + r));
        drain(200);

        // Backpressure on a 16-beat packet from input 1.
        strict    = 1'b0;
        rnd_ready = 1'b1;
        load_pkt(1, 16, 64'h100, 3'd2, 8'h11);
        drain(300);

        // Single-beat packets on inputs 0 and 3.
        do_reset(2, 1'b0);
        strict    = 1'b1;
        rnd_ready = 1'b0;
        load_pkt(0, 1, 64'hA0, 3'd5, 8'h7A);
        load_pkt(3, 1, 64'hA3, 3'd5, 8'h7A);
        drain(50);

        // Random mixed traffic with valid gaps and random backpressure.
        strict    = 1'b0;
        gaps      = 1'b1;
        rnd_ready = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < RX_DIR; i++)
                load_pkt(i, $urandom_range(1, 6), '0, EMPTY_WIDTH'($urandom_range(0, 7)),
                         CHANNEL_WIDTH'($urandom));
        drain(2000);

        // Reset while beat 3 of an 8-beat packet from input 1 is on the bus.
        strict    = 1'b1;
        gaps      = 1'b0;
        rnd_ready = 1'b0;
        load_pkt(1, 8, 64'h200, '0, 8'h22);
        got = 0;
        c   = 0;
        while (got < 2 && c < 50) begin
            step();
            if (acc[1]) got++;
            c++;
        end
        if (got < 2) fail_now("midreset_setup", "input 1 beats not accepted in time");
        do_reset(2, 1'b0);
        load_pkt(1, 2, '0, '0, 8'h31);
        load_pkt(3, 2, '0, '0, 8'h33);
        load_pkt(0, 2, '0, '0, 8'h30);
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
